// File: rtl/max_pooling_mul_pipe_sat_pkg.sv
// Shared constants and helpers for the pipelined saturating multiplier.
package max_pooling_mul_pkg;

  localparam int RND_TRUNC   = 0;
  localparam int RND_HALF_UP = 1;
  localparam int SAT_WRAP    = 0;
  localparam int SAT_CLAMP   = 1;

  typedef struct packed {
    logic signed [63:0] lo;
    logic signed [63:0] hi;
  } range_t;

  // Two's-complement limits of a w-bit signed result, widened to 64 bits.
  function automatic range_t dout_range(input int unsigned w);
    range_t r;
    r.hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    r.lo = -(64'sd1 <<< (w - 1));
    return r;
  endfunction

endpackage

// File: rtl/max_pooling_mul_pipe_sat_if.sv
// Operand/result valid-ready bus of the saturating multiplier.
interface max_pooling_mul_pipe_sat_if #(
  parameter int din0_WIDTH = 16,
  parameter int din1_WIDTH = 16,
  parameter int dout_WIDTH = 16
);
  logic                         in_valid;
  logic                         in_ready;
  logic signed [din0_WIDTH-1:0] din0;
  logic signed [din1_WIDTH-1:0] din1;
  logic                         out_valid;
  logic                         out_ready;
  logic signed [dout_WIDTH-1:0] dout;
  logic                         out_sat;

  modport master (
    output in_valid, din0, din1, out_ready,
    input  in_ready, out_valid, dout, out_sat
  );

  modport slave (
    input  in_valid, din0, din1, out_ready,
    output in_ready, out_valid, dout, out_sat
  );
endinterface

// File: rtl/max_pooling_mul_pipe_sat_rnd_sat.sv
// Combinational narrowing of a full-width product: round/shift, then clamp or wrap.
module max_pooling_mul_rnd_sat
  import max_pooling_mul_pkg::*;
#(
  parameter int PW         = 32,
  parameter int dout_WIDTH = 16,
  parameter int FRAC_BITS  = 8,
  parameter int RND_MODE   = RND_HALF_UP,
  parameter int SAT_MODE   = SAT_CLAMP
) (
  input  logic signed [PW-1:0]         i_prod,
  output logic signed [dout_WIDTH-1:0] o_dout,
  output logic                         o_sat
);

  localparam range_t     RNG      = dout_range(dout_WIDTH);
  localparam logic [PW:0] ONE      = 1;
  // Half an output LSB; collapses to zero when FRAC_BITS is 0.
  localparam logic [PW:0] HALF_LSB = (ONE << FRAC_BITS) >> 1;

  function automatic logic signed [PW:0] round_shift(input logic signed [PW-1:0] p);
    logic signed [PW:0] acc;
    acc = p;
    if (RND_MODE == RND_HALF_UP) acc = acc + $signed(HALF_LSB);
    return acc >>> FRAC_BITS;
  endfunction

  // Returns {sat, value}.
  function automatic logic [dout_WIDTH:0] saturate(input logic signed [PW:0] r);
    logic signed [63:0] r64;
    r64 = r;
    if (SAT_MODE == SAT_CLAMP && r64 > RNG.hi) return {1'b1, RNG.hi[dout_WIDTH-1:0]};
    if (SAT_MODE == SAT_CLAMP && r64 < RNG.lo) return {1'b1, RNG.lo[dout_WIDTH-1:0]};
    return {1'b0, r64[dout_WIDTH-1:0]};
  endfunction

  always_comb begin
    {o_sat, o_dout} = saturate(round_shift(i_prod));
  end

endmodule

// File: rtl/max_pooling_mul_pipe_sat.sv
// Pipelined signed multiplier with valid/ready stall, rounding/saturation and a clamp counter.
module max_pooling_mul_pipe_sat
  import max_pooling_mul_pkg::*;
#(
  parameter int din0_WIDTH = 16,
  parameter int din1_WIDTH = 16,
  parameter int dout_WIDTH = 16,
  parameter int FRAC_BITS  = 8,
  parameter int NUM_STAGE  = 2,
  parameter int RND_MODE   = RND_HALF_UP,
  parameter int SAT_MODE   = SAT_CLAMP,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                 ap_clk,
  input  logic                 ap_rst_n,
  max_pooling_mul_pipe_sat_if.slave io,
  input  logic                 sat_clr,
  output logic [CNT_WIDTH-1:0] sat_count
);

  localparam int PW = din0_WIDTH + din1_WIDTH;

  logic                         w_en;
  logic                         w_vld_last;
  logic signed [PW-1:0]         w_prod_last;
  logic signed [dout_WIDTH-1:0] w_dout;
  logic                         w_sat;

  logic                         r_out_valid;
  logic signed [dout_WIDTH-1:0] r_dout;
  logic                         r_out_sat;
  logic [CNT_WIDTH-1:0]         r_sat_count;

  // One global enable: every stage moves unless a result is waiting unaccepted.
  assign w_en        = !r_out_valid || io.out_ready;
  assign io.in_ready = w_en;

  generate
    if (NUM_STAGE == 1) begin : g_s1
      assign w_prod_last = io.din0 * io.din1;
      assign w_vld_last  = io.in_valid;
    end else begin : g_sn
      logic signed [din0_WIDTH-1:0] r_a_p0;
      logic signed [din1_WIDTH-1:0] r_b_p0;
      logic                         r_vld_p0;
      logic signed [PW-1:0]         w_prod_p0;

      // stage 1: operand registers
      always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n)  r_vld_p0 <= 1'b0;
        else if (w_en)  r_vld_p0 <= io.in_valid;
      end

      always_ff @(posedge ap_clk) begin
        if (w_en) begin
          r_a_p0 <= io.din0;
          r_b_p0 <= io.din1;
        end
      end

      assign w_prod_p0 = r_a_p0 * r_b_p0;

      if (NUM_STAGE == 2) begin : g_nodly
        assign w_prod_last = w_prod_p0;
        assign w_vld_last  = r_vld_p0;
      end else begin : g_dly
        localparam int DLY = NUM_STAGE - 2;
        logic signed [PW-1:0] r_prod_pd [DLY];
        logic                 r_vld_pd  [DLY];

        // stages 2..NUM_STAGE-1: product delay line
        always_ff @(posedge ap_clk or negedge ap_rst_n) begin
          if (!ap_rst_n) begin
            for (int i = 0; i < DLY; i++) r_vld_pd[i] <= 1'b0;
          end else if (w_en) begin
            r_vld_pd[0] <= r_vld_p0;
            for (int i = 1; i < DLY; i++) r_vld_pd[i] <= r_vld_pd[i-1];
          end
        end

        always_ff @(posedge ap_clk) begin
          if (w_en) begin
            r_prod_pd[0] <= w_prod_p0;
            for (int i = 1; i < DLY; i++) r_prod_pd[i] <= r_prod_pd[i-1];
          end
        end

        assign w_prod_last = r_prod_pd[DLY-1];
        assign w_vld_last  = r_vld_pd[DLY-1];
      end
    end
  endgenerate

  max_pooling_mul_rnd_sat #(
    .PW        (PW),
    .dout_WIDTH(dout_WIDTH),
    .FRAC_BITS (FRAC_BITS),
    .RND_MODE  (RND_MODE),
    .SAT_MODE  (SAT_MODE)
  ) u_rnd_sat (
    .i_prod(w_prod_last),
    .o_dout(w_dout),
    .o_sat (w_sat)
  );

  // final stage: narrowed result register
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_out_valid <= 1'b0;
      r_dout      <= '0;
      r_out_sat   <= 1'b0;
    end else if (w_en) begin
      r_out_valid <= w_vld_last;
      if (w_vld_last) begin
        r_dout    <= w_dout;
        r_out_sat <= w_sat;
      end
    end
  end

  // Clear wins over a same-cycle increment; the count sticks at all-ones.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n)
      r_sat_count <= '0;
    else if (sat_clr)
      r_sat_count <= '0;
    else if (r_out_valid && io.out_ready && r_out_sat && !(&r_sat_count))
      r_sat_count <= r_sat_count + 1'b1;
  end

  assign io.out_valid = r_out_valid;
  assign io.dout      = r_dout;
  assign io.out_sat   = r_out_sat;
  assign sat_count    = r_sat_count;

endmodule

// File: tb/tb_max_pooling_mul_pipe_sat.sv
// Directed and table-driven bench for max_pooling_mul_pipe_sat across NUM_STAGE=1..4.
module tb_max_pooling_mul_pipe_sat;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b1;
  logic sat_clr = 1'b0;
  logic [15:0] din0 = '0;
  logic [15:0] din1 = '0;

  logic [3:0]       w_ov, w_ir, w_sat;
  logic [3:0][15:0] w_dout, w_cnt;
  logic             t_ov, t_ir, t_sat;
  logic [15:0]      t_dout, t_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Index g carries NUM_STAGE = g+1, round-half-up, clamp.
  for (genvar g = 0; g < 4; g++) begin : g_ns
    max_pooling_mul_pipe_sat_if #(.din0_WIDTH(16), .din1_WIDTH(16), .dout_WIDTH(16)) bus ();
    assign bus.in_valid  = in_valid;
    assign bus.din0      = din0;
    assign bus.din1      = din1;
    assign bus.out_ready = out_ready;
    assign w_ov[g]   = bus.out_valid;
    assign w_ir[g]   = bus.in_ready;
    assign w_sat[g]  = bus.out_sat;
    assign w_dout[g] = bus.dout;
    max_pooling_mul_pipe_sat #(.NUM_STAGE(g + 1)) dut (
      .ap_clk   (clk),
      .ap_rst_n (rst_n),
      .io       (bus),
      .sat_clr  (sat_clr),
      .sat_count(w_cnt[g])
    );
  end

  // Truncate + wrap variant, NUM_STAGE=2.
  max_pooling_mul_pipe_sat_if #(.din0_WIDTH(16), .din1_WIDTH(16), .dout_WIDTH(16)) bus_t ();
  assign bus_t.in_valid  = in_valid;
  assign bus_t.din0      = din0;
  assign bus_t.din1      = din1;
  assign bus_t.out_ready = out_ready;
  assign t_ov   = bus_t.out_valid;
  assign t_ir   = bus_t.in_ready;
  assign t_sat  = bus_t.out_sat;
  assign t_dout = bus_t.dout;
  max_pooling_mul_pipe_sat #(.NUM_STAGE(2), .RND_MODE(0), .SAT_MODE(0)) dut_t (
    .ap_clk   (clk),
    .ap_rst_n (rst_n),
    .io       (bus_t),
    .sat_clr  (sat_clr),
    .sat_count(t_cnt)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: {sat, dout} for 16x16 -> 16, FRAC_BITS=8.
  function automatic logic [16:0] ref_mul(input logic [15:0] a, input logic [15:0] b,
                                         input bit rnd, input bit sat);
    longint p;
    longint r;
    p = longint'($signed(a)) * longint'($signed(b));
    if (rnd) p = p + 128;
    r = p >>> 8;
    if (sat && r > 32767)  return {1'b1, 16'h7FFF};
    if (sat && r < -32768) return {1'b1, 16'h8000};
    return {1'b0, r[15:0]};
  endfunction

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] exp_d;
    logic        exp_s;
    logic [15:0] exp_t;
  } vec_t;

  vec_t vecs[11];

  logic        hv [0:255];
  logic [16:0] hd [0:255];

  initial begin
    int sent, recv, cnt;
    logic stall_prev;
    logic [15:0] held;
    logic [16:0] e;

    vecs[0]  = '{16'h0180, 16'h0200, 16'h0300, 1'b0, 16'h0300};
    vecs[1]  = '{16'h0001, 16'h0080, 16'h0001, 1'b0, 16'h0000};
    vecs[2]  = '{16'hFFFF, 16'h0080, 16'h0000, 1'b0, 16'hFFFF};
    vecs[3]  = '{16'h7F00, 16'h7F00, 16'h7FFF, 1'b1, 16'h0100};
    vecs[4]  = '{16'h8000, 16'h7F00, 16'h8000, 1'b1, 16'h8000};
    vecs[5]  = '{16'h0003, 16'h0080, 16'h0002, 1'b0, 16'h0001};
    vecs[6]  = '{16'h00B5, 16'h00B5, 16'h0080, 1'b0, 16'h007F};
    vecs[7]  = '{16'h7FFF, 16'h0100, 16'h7FFF, 1'b0, 16'h7FFF};
    vecs[8]  = '{16'h4000, 16'h0200, 16'h7FFF, 1'b1, 16'h8000};
    vecs[9]  = '{16'h8000, 16'h0100, 16'h8000, 1'b0, 16'h8000};
    vecs[10] = '{16'h0100, 16'hFF80, 16'hFF80, 1'b0, 16'hFF80};

    // Reset state
    repeat (2) tick();
    chk("rst_out_valid", w_ov[1], 0);
    chk("rst_dout", w_dout[1], 0);
    chk("rst_out_sat", w_sat[1], 0);
    chk("rst_sat_count", w_cnt[1], 0);
    chk("rst_in_ready", w_ir[1], 1);
    rst_n = 1'b1;
    tick();

    // Table: latency, rounding, clamp and wrap
    for (int i = 0; i < 11; i++) begin
      din0 = vecs[i].a;
      din1 = vecs[i].b;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      chk($sformatf("lat_early[%0d]", i), w_ov[1], 0);
      tick();
      chk($sformatf("lat_valid[%0d]", i), w_ov[1], 1);
      chk($sformatf("dout[%0d]", i), w_dout[1], vecs[i].exp_d);
      chk($sformatf("sat[%0d]", i), w_sat[1], vecs[i].exp_s);
      chk($sformatf("dout_tw[%0d]", i), t_dout, vecs[i].exp_t);
      chk($sformatf("sat_tw[%0d]", i), t_sat, 0);
    end
    tick();
    chk("sat_count_after_table", w_cnt[1], 3);
    chk("sat_count_wrap_mode", t_cnt, 0);

    // Reset with two results in flight
    din0 = 16'h7F00; din1 = 16'h7F00; in_valid = 1'b1;
    tick();
    din0 = 16'h0180; din1 = 16'h0200;
    tick();
    in_valid = 1'b0;
    chk("inflight_valid", w_ov[1], 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", w_ov[1], 0);
    chk("async_rst_dout", w_dout[1], 0);
    chk("async_rst_sat", w_sat[1], 0);
    chk("async_rst_count", w_cnt[1], 0);
    #2 rst_n = 1'b1;
    cnt = 0;
    repeat (5) begin
      tick();
      if (w_ov[1]) cnt++;
    end
    chk("flush_no_output", cnt, 0);

    // sat_clr against a concurrent saturating handshake
    din0 = 16'h7F00; din1 = 16'h7F00; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    chk("sat_count_one", w_cnt[1], 1);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    chk("sat_pending", w_ov[1] & w_sat[1], 1);
    sat_clr = 1'b1;
    tick();
    sat_clr = 1'b0;
    chk("sat_clr_priority", w_cnt[1], 0);

    // Backpressure: 8 back-to-back pairs, 5-cycle stall mid-stream
    sent = 0; recv = 0; stall_prev = 1'b0; held = '0;
    for (int c = 0; c < 60 && recv < 8; c++) begin
      out_ready = !(c >= 3 && c < 8);
      in_valid  = (sent < 8);
      din0      = 16'((sent + 1) << 8);
      din1      = 16'h0100;
      #1;
      if (w_ov[1] && !out_ready) begin
        chk($sformatf("stall_in_ready[%0d]", c), w_ir[1], 0);
        if (stall_prev) chk($sformatf("stall_hold[%0d]", c), w_dout[1], held);
        held = w_dout[1];
        stall_prev = 1'b1;
      end else begin
        stall_prev = 1'b0;
      end
      if (w_ov[1] && out_ready) begin
        chk($sformatf("bp_dout[%0d]", recv), w_dout[1], 16'((recv + 1) << 8));
        recv++;
      end
      if (in_valid && w_ir[1]) sent++;
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    chk("bp_received", recv, 8);
    chk("bp_sent", sent, 8);
    cnt = 0;
    repeat (4) begin
      tick();
      if (w_ov[1]) cnt++;
    end
    chk("bp_no_duplicate", cnt, 0);

    // NUM_STAGE sweep against the reference model
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    for (int k = 0; k < 200; k++) begin
      in_valid = ($urandom % 4) != 0;
      din0 = 16'($urandom);
      din1 = ($urandom % 2) ? 16'($urandom) : 16'($urandom % 512);
      hv[k] = in_valid;
      hd[k] = ref_mul(din0, din1, 1'b1, 1'b1);
      tick();
      for (int g = 0; g < 4; g++) begin
        if (k - g >= 0) begin
          chk($sformatf("sw_valid[ns%0d,%0d]", g + 1, k), w_ov[g], hv[k-g]);
          if (hv[k-g]) begin
            e = hd[k-g];
            chk($sformatf("sw_dout[ns%0d,%0d]", g + 1, k), w_dout[g], e[15:0]);
            chk($sformatf("sw_sat[ns%0d,%0d]", g + 1, k), w_sat[g], e[16]);
          end
        end else begin
          chk($sformatf("sw_fill[ns%0d,%0d]", g + 1, k), w_ov[g], 0);
        end
      end
    end
    in_valid = 1'b0;

    // Counter pegs at all-ones after more than 2^16 clamps
    sat_clr = 1'b1;
    tick();
    sat_clr = 1'b0;
    din0 = 16'h7F00; din1 = 16'h7F00; in_valid = 1'b1;
    repeat (65540) tick();
    in_valid = 1'b0;
    repeat (6) tick();
    for (int g = 0; g < 4; g++)
      chk($sformatf("sat_count_peg[ns%0d]", g + 1), w_cnt[g], 16'hFFFF);
    chk("sat_count_peg_wrap_mode", t_cnt, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
